// File: rtl/mole_hit_detector.sv
// Turns raw whack-a-mole pushbuttons into single-cycle hit/miss scoring events.
// Optional build macro: MISS_PENALTY_EN enables the player_missed pulse.
`timescale 1ns/1ps
module mole_hit_detector #(
   parameter int unsigned N_MOLES         = 4,
   parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
   input  logic               clkIn,
   input  logic               reset,
   input  logic               game_active,
   input  logic [N_MOLES-1:0] btn_raw,
   input  logic [N_MOLES-1:0] mole_up,
   output logic               player_scored,
   output logic [N_MOLES-1:0] mole_hit,
   output logic               player_missed
);

   localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

   logic [N_MOLES-1:0] sync_q1;
   logic [N_MOLES-1:0] sync_q2;
   logic [N_MOLES-1:0] btn_stable;
   logic [N_MOLES-1:0] stable_q;
   logic [CNT_W-1:0]   db_cnt [N_MOLES];

   logic [N_MOLES-1:0] press_c;
   logic [N_MOLES-1:0] hit_cand_c;
   logic [N_MOLES-1:0] hit_sel_c;

   // Two-flop synchroniser for the asynchronous buttons
   always_ff @(posedge clkIn or negedge reset) begin
      if (!reset) begin
         sync_q1 <= '0;
         sync_q2 <= '0;
      end else begin
         sync_q1 <= btn_raw;
         sync_q2 <= sync_q1;
      end
   end

   // Debounce: a level change is accepted once the counter has saturated at CNT_MAX
   always_ff @(posedge clkIn or negedge reset) begin
      if (!reset) begin
         btn_stable <= '0;
         for (int i = 0; i < int'(N_MOLES); i++) begin
            db_cnt[i] <= '0;
         end
      end else begin
         for (int i = 0; i < int'(N_MOLES); i++) begin
            if (sync_q2[i] != btn_stable[i]) begin
               if (db_cnt[i] == CNT_MAX) begin
                  btn_stable[i] <= sync_q2[i];
                  db_cnt[i]     <= '0;
               end else begin
                  db_cnt[i] <= db_cnt[i] + CNT_W'(1);
               end
            end else begin
               db_cnt[i] <= '0;
            end
         end
      end
   end

   // Previous debounced level for rising-edge detection
   always_ff @(posedge clkIn or negedge reset) begin
      if (!reset) begin
         stable_q <= '0;
      end else begin
         stable_q <= btn_stable;
      end
   end

   // Lowest-index hit candidate wins; the others are dropped
   always_comb begin
      press_c    = btn_stable & ~stable_q;
      hit_cand_c = press_c & mole_up & {N_MOLES{game_active}};
      hit_sel_c  = hit_cand_c & (~hit_cand_c + N_MOLES'(1));
   end

   always_ff @(posedge clkIn or negedge reset) begin
      if (!reset) begin
         player_scored <= 1'b0;
         mole_hit      <= '0;
      end else begin
         player_scored <= |hit_sel_c;
         mole_hit      <= hit_sel_c;
      end
   end

`ifdef MISS_PENALTY_EN
   // Any press on a lowered mole collapses into one miss pulse
   always_ff @(posedge clkIn or negedge reset) begin
      if (!reset) begin
         player_missed <= 1'b0;
      end else begin
         player_missed <= game_active & (|(press_c & ~mole_up));
      end
   end
`else
   assign player_missed = 1'b0;
`endif

endmodule

// File: tb/tb_mole_hit_detector.sv
// Self-checking bench for mole_hit_detector: directed scenarios plus random traffic
// against a sliding-window behavioural model of the debounced button levels.
`timescale 1ns/1ps
module tb_mole_hit_detector;

   localparam int D = 4;
   localparam int N = 4;

   logic         clkIn;
   logic         reset;
   logic         game_active;
   logic [N-1:0] btn_raw;
   logic [N-1:0] mole_up;
   logic         player_scored;
   logic [N-1:0] mole_hit;
   logic         player_missed;

   int checks = 0;
   int errors = 0;
   int pulses;
   int misses;
   logic [N-1:0] last_hit;
   int exp_miss;

   mole_hit_detector #(.N_MOLES(N), .DEBOUNCE_CYCLES(D)) dut (
      .clkIn         (clkIn),
      .reset         (reset),
      .game_active   (game_active),
      .btn_raw       (btn_raw),
      .mole_up       (mole_up),
      .player_scored (player_scored),
      .mole_hit      (mole_hit),
      .player_missed (player_missed)
   );

   initial clkIn = 1'b0;
   always #5 clkIn = ~clkIn;

   // Reference model: a level flips once the raw samples feeding the last D+1
   // post-sync evaluations all disagree with it; outputs follow one edge later.
   logic [N-1:0] hist [$];
   logic [N-1:0] m_stable;
   logic [N-1:0] m_pend;
   logic [N-1:0] m_hit;
   logic         m_scored;
   logic         m_missed;

   always @(posedge clkIn or negedge reset) begin
      if (!reset) begin
         hist.delete();
         m_stable = '0;
         m_pend   = '0;
         m_hit    = '0;
         m_scored = 1'b0;
         m_missed = 1'b0;
      end else begin
         m_hit    = '0;
         m_scored = 1'b0;
         m_missed = 1'b0;
         if (game_active) begin
            for (int i = N - 1; i >= 0; i--)
               if (m_pend[i] && mole_up[i]) m_hit = N'(1 << i);
            m_scored = (m_hit != '0);
`ifdef MISS_PENALTY_EN
            m_missed = |(m_pend & ~mole_up);
`endif
         end
         hist.push_back(btn_raw);
         m_pend = '0;
         for (int i = 0; i < N; i++) begin
            bit all_diff;
            all_diff = 1'b1;
            for (int j = 0; j <= D; j++) begin
               int idx;
               logic [N-1:0] smp;
               logic v;
               idx = hist.size() - 3 - j;
               if (idx >= 0) begin
                  smp = hist[idx];
                  v   = smp[i];
               end else begin
                  v = 1'b0;
               end
               if (v == m_stable[i]) all_diff = 1'b0;
            end
            if (all_diff) begin
               if (!m_stable[i]) m_pend[i] = 1'b1;
               m_stable[i] = ~m_stable[i];
            end
         end
         if (hist.size() > 64) void'(hist.pop_front());
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance n cycles, comparing every output against the model at each negedge
   task automatic run(input int n);
      repeat (n) begin
         @(negedge clkIn);
         chk("player_scored", 32'(player_scored), 32'(m_scored));
         chk("mole_hit", 32'(mole_hit), 32'(m_hit));
         chk("player_missed", 32'(player_missed), 32'(m_missed));
         if (player_scored === 1'b1) begin
            pulses++;
            last_hit = mole_hit;
         end
         if (player_missed === 1'b1) misses++;
      end
   endtask

   task automatic clr();
      pulses   = 0;
      misses   = 0;
      last_hit = '0;
   endtask

   task automatic check_reset_outputs(input string tag);
      #1;
      chk({tag, "_scored"}, 32'(player_scored), 32'd0);
      chk({tag, "_hit"}, 32'(mole_hit), 32'd0);
      chk({tag, "_missed"}, 32'(player_missed), 32'd0);
   endtask

   initial begin
`ifdef MISS_PENALTY_EN
      exp_miss = 1;
`else
      exp_miss = 0;
`endif
      reset       = 1'b0;
      game_active = 1'b0;
      btn_raw     = '0;
      mole_up     = '0;
      clr();
      run(3);
      check_reset_outputs("reset_state");
      reset = 1'b1;
      run(4);

      // Clean hit, held button must not repeat
      game_active = 1'b1;
      mole_up     = 4'b0100;
      btn_raw     = 4'b0100;
      clr();
      run(16);
      chk("clean_pulses", 32'(pulses), 32'd1);
      chk("clean_hit", 32'(last_hit), 32'h4);
      btn_raw = '0;
      run(10);

      // Bounce rejection then a real hold
      mole_up = 4'b0010;
      clr();
      for (int k = 0; k < 10; k++) begin
         btn_raw = 4'b0010;
         run(2);
         btn_raw = 4'b0000;
         run(2);
      end
      chk("bounce_pulses", 32'(pulses), 32'd0);
      btn_raw = 4'b0010;
      run(12);
      chk("bounce_hold_pulses", 32'(pulses), 32'd1);
      btn_raw = '0;
      run(10);

      // Simultaneous hits: lowest index wins
      mole_up = 4'b1010;
      btn_raw = 4'b1010;
      clr();
      run(14);
      chk("simul_pulses", 32'(pulses), 32'd1);
      chk("simul_hit", 32'(last_hit), 32'h2);
      btn_raw = '0;
      run(10);

      // Inactive game, then hold across start, then re-press
      game_active = 1'b0;
      mole_up     = 4'b0001;
      btn_raw     = 4'b0001;
      clr();
      run(12);
      game_active = 1'b1;
      run(12);
      chk("inactive_pulses", 32'(pulses), 32'd0);
      btn_raw = '0;
      run(10);
      btn_raw = 4'b0001;
      run(12);
      chk("repress_pulses", 32'(pulses), 32'd1);
      btn_raw = '0;
      run(10);

      // Miss on a lowered mole
      mole_up = '0;
      btn_raw = 4'b0001;
      clr();
      run(12);
      chk("miss_scored", 32'(pulses), 32'd0);
      chk("miss_count", 32'(misses), 32'(exp_miss));
      btn_raw = '0;
      run(10);

      // Reset two cycles into a debounce, button still held afterwards
      mole_up = 4'b0100;
      btn_raw = 4'b0100;
      run(4);
      reset = 1'b0;
      check_reset_outputs("rst_debounce");
      run(3);
      reset = 1'b1;
      clr();
      run(12);
      chk("post_reset_pulses", 32'(pulses), 32'd1);
      btn_raw = '0;
      run(10);

      // Reset in the middle of a hit pulse
      btn_raw = 4'b0100;
      for (int k = 0; k < 14; k++) begin
         run(1);
         if (m_scored) break;
      end
      chk("pulse_seen", 32'(player_scored), 32'd1);
      reset = 1'b0;
      check_reset_outputs("rst_pulse");
      run(2);
      reset = 1'b1;
      clr();
      run(12);
      chk("post_pulse_reset_pulses", 32'(pulses), 32'd1);
      btn_raw = '0;
      run(10);

      // Random traffic against the model
      for (int c = 0; c < 4000; c++) begin
         run(1);
         for (int i = 0; i < N; i++) begin
            if ($urandom_range(0, 9) == 0) btn_raw[i] = ~btn_raw[i];
         end
         if ($urandom_range(0, 5) == 0) mole_up = N'($urandom_range(0, 15));
         if ($urandom_range(0, 60) == 0) game_active = ~game_active;
         if ($urandom_range(0, 799) == 0) begin
            reset = 1'b0;
            check_reset_outputs("rst_random");
            run(2);
            reset = 1'b1;
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
